// File: rtl/div_unit.sv
// Multi-cycle signed restoring divider producing MIPS DIV results:
// quotient truncated toward zero on lo_out, remainder with the dividend's sign on hi_out.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     divisor;
    logic                 neg_quot;
    logic                 neg_rem;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        rem_shift;
    logic [WIDTH:0]          trial;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // The most negative input negates to itself, which read unsigned is 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        return (v < 0) ? negate(v) : v;
    endfunction

    assign a_s = a;
    assign b_s = b;

    // Remainder stays below the divisor (<= 2^(WIDTH-1)), so the shifted value fits WIDTH bits
    // and bit WIDTH of the widened subtraction is the borrow.
    assign rem_shift = {rem[WIDTH-2:0], quot[WIDTH-1]};
    assign trial     = {1'b0, rem_shift} - {1'b0, divisor};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            quot     <= '0;
            rem      <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            lo_out   <= '0;
            hi_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            quot     <= abs_val(a_s);
                            divisor  <= abs_val(b_s);
                            neg_rem  <= a_s[WIDTH-1];
                            neg_quot <= a_s[WIDTH-1] ^ b_s[WIDTH-1];
                            rem      <= '0;
                            count    <= '0;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        rem  <= trial[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], 1'b1};
                    end else begin
                        rem  <= rem_shift;
                        quot <= {quot[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    lo_out <= neg_quot ? negate(quot) : quot;
                    hi_out <= neg_rem ? negate(rem) : rem;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus queues expected {lo,hi}, a monitor pops on done.
module tb_div_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] hi_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    int tests = 0;
    int fails = 0;

    logic [2*WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0]   last_lo = '0;
    logic [WIDTH-1:0]   last_hi = '0;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .lo_out(lo_out),
        .hi_out(hi_out),
        .busy(busy),
        .done(done),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [2*WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got lo=0x%08h hi=0x%08h expected no result", lo_out, hi_out);
                end else begin
                    e = exp_q.pop_front();
                    check("lo_out", lo_out, e[2*WIDTH-1:WIDTH]);
                    check("hi_out", hi_out, e[WIDTH-1:0]);
                end
            end
            if (done && div_zero) begin
                tests++;
                fails++;
                $display("FAIL done_and_div_zero: got both 1 expected at most one");
            end
        end
    end

    // Called at the negedge right after the accepting edge; counts cycles to done.
    task automatic wait_done(input bit glitch, output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 200) begin
            if (busy) busy_cnt++;
            if (glitch && cyc == 5) begin
                start = 1'b1;
                a = 32'd5;
                b = 32'd5;
            end else if (glitch && cyc == 6) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no done after %0d cycles expected done", cyc);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi, input bit glitch);
        int cyc;
        int bc;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        exp_q.push_back({lo, hi});
        @(negedge clk);
        start = 1'b0;
        wait_done(glitch, cyc, bc);
        check("latency", cyc, WIDTH + 1);
        check("busy_cycles", bc, WIDTH + 1);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        last_lo = lo;
        last_hi = hi;
    endtask

    initial begin
        int cyc;
        int bc;
        bit saw_done;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset_lo", lo_out, 32'd0);
        check("reset_hi", hi_out, 32'd0);
        check("reset_flags", {29'b0, busy, done, div_zero}, 32'd0);
        reset = 1'b0;

        run_op(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
        run_op(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_op(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
        run_op(32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF, 1'b0);
        run_op(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
        run_op(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b0);
        run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b1);

        // Divide by zero: one-cycle flag, no busy, results untouched.
        @(negedge clk);
        a = 32'd9;
        b = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("div_zero_pulse", {31'b0, div_zero}, 32'd1);
        check("div_zero_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("div_zero_clear", {30'b0, div_zero, done}, 32'd0);
        check("div_zero_lo_hold", lo_out, last_lo);
        check("div_zero_hi_hold", hi_out, last_hi);

        // Abort mid-RUN with reset: no result may ever appear.
        a = 32'd50;
        b = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_lo", lo_out, 32'd0);
        check("abort_hi", hi_out, 32'd0);
        check("abort_flags", {29'b0, busy, done, div_zero}, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'b0, saw_done}, 32'd0);
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Back-to-back: start held across FIN, second op accepted at the next IDLE edge.
        @(negedge clk);
        a = 32'd20;
        b = 32'd6;
        start = 1'b1;
        exp_q.push_back({32'd3, 32'd2});
        exp_q.push_back({32'hFFFFFFFD, 32'hFFFFFFFE});
        @(negedge clk);
        wait_done(1'b0, cyc, bc);
        check("b2b_first_latency", cyc, WIDTH + 1);
        a = 32'hFFFFFFEC;
        b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_busy", {31'b0, busy}, 32'd1);
        wait_done(1'b0, cyc, bc);
        check("b2b_second_latency", cyc, WIDTH + 1);
        @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1, rising-edge clock of the CPU.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, div request from control unit, level-sampled.
REQ-006 Port a, input, WIDTH, signed dividend (A register output).
REQ-007 Port b, input, WIDTH, signed divisor (B register output).
REQ-008 Port lo_out, output, WIDTH, registered quotient, feeds LO register mux.
REQ-009 Port hi_out, output, WIDTH, registered remainder, feeds HI register mux.
REQ-010 Port busy, output, 1, high while the state is not IDLE.
REQ-011 Port done, output, 1, one-cycle pulse when lo_out/hi_out are updated.
REQ-012 Port div_zero, output, 1, one-cycle pulse on a divide-by-zero request (drives divzero exception, vector 255).

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FIN, with a step counter of ceil(log2(WIDTH))+1 bits.
REQ-014 IDLE, start=1, b!=0: the edge SHALL latch |a|, |b|, sign(a), sign(a) XOR sign(b), clear the partial remainder and counter, and go to RUN.
REQ-015 IDLE, start=1, b==0: the edge SHALL set div_zero=1 for exactly one cycle, stay in IDLE, and leave lo_out/hi_out unchanged.
REQ-016 start SHALL be ignored when the state is not IDLE.
REQ-017 RUN: each edge SHALL perform one restoring step: shift {rem,quot} left by 1, trial-subtract |b|, keep the result if non-negative and set quotient bit 1, otherwise restore and set it to 0.
REQ-018 RUN SHALL last exactly WIDTH edges, then go to FIN.
REQ-019 The FIN edge SHALL load lo_out with the quotient (negated if the sign flag is set) and hi_out with the remainder (negated if the dividend was negative), set done=1, and go to IDLE.
REQ-020 Latency: if start is accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH+1, i.e. edge N+33 for WIDTH=32.
REQ-021 busy SHALL be high from edge N through edge N+WIDTH+1 and SHALL fall at the same edge where done rises.
REQ-022 Quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend (MIPS DIV semantics).
REQ-023 The magnitude of the most negative value SHALL be treated as unsigned 2^(WIDTH-1).
REQ-024 Most-negative / -1 SHALL yield lo_out = 0x80000000 and hi_out = 0 with no error flag.
REQ-025 Negation SHALL be two's complement modulo 2^WIDTH.
REQ-026 lo_out and hi_out SHALL hold their value between operations and change only at a FIN edge or on reset.
REQ-027 done and div_zero SHALL never be high in the same cycle.
REQ-028 A start held high across FIN SHALL be accepted only at the first IDLE edge after FIN, so back-to-back operations are allowed with no gap beyond IDLE.

Reset
REQ-029 When reset=1 at an edge: state=IDLE, counter=0, internal regs=0, lo_out=0, hi_out=0, busy=0, done=0, div_zero=0.
REQ-030 Reset SHALL take priority over start.
REQ-031 Reset in RUN or FIN SHALL abort the operation with no done pulse and no partial result visible.
REQ-032 The first start SHALL be accepted at the first edge with reset=0.

Verification
REQ-033 a=7, b=2, start for 1 cycle -> busy for 33 cycles, then done=1 with lo_out=3, hi_out=1.
REQ-034 Signed operands -> -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF; 7/-2: lo=0xFFFFFFFD, hi=1; -7/-2: lo=3, hi=0xFFFFFFFF.
REQ-035 b=0, start -> div_zero=1 for one cycle, busy stays 0, no done, lo/hi keep their prior values.
REQ-036 a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0; a=0xFFFFFFFF, b=0x80000000 -> lo=0, hi=0xFFFFFFFF.
REQ-037 Start accepted, reset at the 10th RUN cycle -> all outputs 0 next cycle, no done; a new start then completes 100/7 -> lo=14, hi=2.
REQ-038 Second start pulsed mid-RUN with different operands -> ignored; results match the first operands only.
